booth_multiplier: RTL and testbench

//  Iterative radix-2 Booth multiplier for the EX stage; issues one add/subtract per cycle.

---
 rtl/booth_pkg.sv | 16 +
 rtl/booth_multiplier_addsub.sv | 20 ++
 rtl/booth_multiplier.sv | 151 +++++++++++++++
 tb/tb_booth_multiplier.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-2 Booth multiplier.
package booth_pkg;

  // Controller states: idle, iterating, presenting the result for one cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } booth_state_t;

  // Width of a counter able to hold 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/booth_multiplier_addsub.sv
// Two's-complement adder/subtractor used as the only arithmetic unit of the
// Booth multiplier. addSub_i = 1 selects a_i - b_i, otherwise a_i + b_i.
module addSubtract #(
  parameter int WIDTH = 65
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             addSub_i,
  output logic [WIDTH-1:0] sum_o
);

  logic [WIDTH-1:0] bOperand;

  // Subtraction is done as a + ~b + 1, sharing a single carry chain.
  always_comb begin
    bOperand = b_i ^ {WIDTH{addSub_i}};
    sum_o    = a_i + bOperand + {{(WIDTH-1){1'b0}}, addSub_i};
  end

endmodule

// File: rtl/booth_multiplier.sv
// Iterative radix-2 Booth multiplier: one add/subtract plus one arithmetic
// right shift of {ACC,Q,q_1} per cycle, WIDTH iterations, then a one-cycle
// DONE state carrying the 2*WIDTH-bit product.
// Optional build macro BOOTH_UNSIGNED_EN adds a signed_op input; operands are
// then extended by one bit (sign or zero) and one extra iteration is run.
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef BOOTH_UNSIGNED_EN
  input  logic                 signed_op,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

`ifdef BOOTH_UNSIGNED_EN
  localparam int EXT = 1;
`else
  localparam int EXT = 0;
`endif

  // OPW: extended operand width; ACCW: accumulator is one bit wider so the
  // most-negative multiplicand can be subtracted without overflow.
  localparam int OPW   = WIDTH + EXT;
  localparam int ACCW  = OPW + 1;
  localparam int NITER = OPW;
  localparam int CNTW  = cnt_width(NITER);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NITER - 1);

  booth_state_t           state_q, state_d;
  logic [ACCW-1:0]        acc_q, acc_d;
  logic [ACCW-1:0]        m_q, m_d;
  logic [OPW-1:0]         q_q, q_d;
  logic                   q1_q, q1_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     product_q, product_d;

  logic [OPW-1:0]         opA, opB;
  logic [ACCW-1:0]        mLoad;
  logic [ACCW-1:0]        sum;
  logic [ACCW-1:0]        accSel;
  logic [ACCW-1:0]        accSh;
  logic [OPW-1:0]         qSh;
  logic                   q1Sh;

  // Extend the operands to the internal operand width and form the multiplicand.
  always_comb begin
`ifdef BOOTH_UNSIGNED_EN
    opA = {signed_op & a[WIDTH-1], a};
    opB = {signed_op & b[WIDTH-1], b};
`else
    opA = a;
    opB = b;
`endif
    mLoad = {opA[OPW-1], opA};
  end

  addSubtract #(
    .WIDTH(ACCW)
  ) u_addSub (
    .a_i     (acc_q),
    .b_i     (m_q),
    .addSub_i(q_q[0]),
    .sum_o   (sum)
  );

  // Booth recoding picks the adder result on 10/01, keeps ACC on 00/11,
  // then the whole {ACC,Q,q_1} register shifts right arithmetically.
  always_comb begin
    accSel = (q_q[0] ^ q1_q) ? sum : acc_q;
    accSh  = {accSel[ACCW-1], accSel[ACCW-1:1]};
    qSh    = {accSel[0], q_q[OPW-1:1]};
    q1Sh   = q_q[0];
  end

  // Next-state logic for the controller and the datapath registers.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    m_d       = m_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          m_d     = mLoad;
          acc_d   = '0;
          q_d     = opB;
          q1_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        acc_d = accSh;
        q_d   = qSh;
        q1_d  = q1Sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d   = DONE;
          product_d = {accSh[2*WIDTH-OPW-1:0], qSh};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Status outputs are decoded straight from the state register.
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    product = product_q;
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier with WIDTH=8.
module tb_booth_multiplier;

  localparam int WIDTH = 8;
`ifdef BOOTH_UNSIGNED_EN
  localparam int NITER = 9;
`else
  localparam int NITER = 8;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b1;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int testsRun = 0;
  int testsFailed = 0;
  logic [15:0] expQ[$];

  always #5 clk = ~clk;

  booth_multiplier #(
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .a        (a),
    .b        (b),
`ifdef BOOTH_UNSIGNED_EN
    .signed_op(signed_op),
`endif
    .busy     (busy),
    .done     (done),
    .product  (product)
  );

  // One operation: drive start for one edge, push the expected product,
  // then wait a bounded number of cycles for done and pop/compare.
  task automatic runOp(input logic [7:0] aIn, input logic [7:0] bIn,
                       input logic signedIn, input logic [15:0] expProd,
                       input string tag);
    bit seen;
    logic [15:0] expV;
    expV = '0;
    @(negedge clk);
    a = aIn;
    b = bIn;
    signed_op = signedIn;
    start = 1'b1;
    expQ.push_back(expProd);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    testsRun++;
    if (busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL %s_busy_after_load: got %b expected 1", tag, busy);
    end
    seen = 1'b0;
    for (int k = 1; k <= NITER + 4 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        testsRun++;
        if (k != NITER) begin
          testsFailed++;
          $display("[TB] FAIL %s_latency: done after %0d edges, expected %0d", tag, k, NITER);
        end
        expV = expQ.pop_front();
        testsRun++;
        if (product !== expV) begin
          testsFailed++;
          $display("[TB] FAIL %s_product: got %h expected %h", tag, product, expV);
        end
      end
    end
    if (!seen) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s_timeout: no done within %0d cycles", tag, NITER + 4);
      expQ.delete();
    end else begin
      @(posedge clk);
      #1;
      testsRun++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL %s_idle_after_done: busy=%b done=%b expected 0/0", tag, busy, done);
      end
      testsRun++;
      if (product !== expV) begin
        testsFailed++;
        $display("[TB] FAIL %s_product_hold: got %h expected %h", tag, product, expV);
      end
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    testsRun++;
    if (done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
    testsRun++;
    if (product !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_product: got %h expected 0000", product);
    end
    @(negedge clk);
    start = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_signed();
    runOp(8'd3,  8'd5,  1'b1, 16'h000F, "pos_pos");
    runOp(8'hFD, 8'd5,  1'b1, 16'hFFF1, "neg_pos");
    runOp(8'h80, 8'h80, 1'b1, 16'h4000, "min_min");
    runOp(8'h7F, 8'h80, 1'b1, 16'hC080, "max_min");
  endtask

  task automatic test_start_held();
    int doneCount;
    int firstDone;
    int secondDone;
    logic [15:0] expV;
    doneCount = 0;
    firstDone = -1;
    secondDone = -1;
    @(negedge clk);
    a = 8'd6;
    b = 8'd7;
    signed_op = 1'b1;
    start = 1'b1;
    expQ.push_back(16'd42);
    @(posedge clk);
    #1;
    for (int k = 1; k <= 2 * NITER + 4; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        doneCount++;
        if (doneCount == 1) firstDone = k;
        if (doneCount == 2) secondDone = k;
        if (expQ.size() > 0) begin
          expV = expQ.pop_front();
          testsRun++;
          if (product !== expV) begin
            testsFailed++;
            $display("[TB] FAIL held_product_%0d: got %h expected %h", doneCount, product, expV);
          end
        end
      end
      if (k == 3) begin
        a = 8'hF9;
        b = 8'd9;
      end
      if (k == NITER + 1) begin
        testsRun++;
        if (busy !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL held_idle_gap: busy=%b expected 0", busy);
        end
      end
      if (k == NITER + 2) begin
        testsRun++;
        if (busy !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL held_reload: busy=%b expected 1", busy);
        end
        start = 1'b0;
        expQ.push_back(16'hFFC1);
      end
    end
    testsRun++;
    if (firstDone != NITER || secondDone != 2 * NITER + 2 || doneCount != 2) begin
      testsFailed++;
      $display("[TB] FAIL held_done_pulses: count=%0d at %0d,%0d expected 2 at %0d,%0d",
               doneCount, firstDone, secondDone, NITER, 2 * NITER + 2);
    end
    expQ.delete();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a = 8'd11;
    b = 8'd13;
    signed_op = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    testsRun++;
    if (busy !== 1'b1 || product === 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL async_pre: busy=%b product=%h expected busy 1, product nonzero", busy, product);
    end
    #1;
    reset_n = 1'b0;
    #1;
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_busy: got %b expected 0", busy);
    end
    testsRun++;
    if (done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_done: got %b expected 0", done);
    end
    testsRun++;
    if (product !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL async_product: got %h expected 0000", product);
    end
    @(negedge clk);
    reset_n = 1'b1;
    runOp(8'd2, 8'hFF, 1'b1, 16'hFFFE, "post_reset");
  endtask

  task automatic test_random();
    logic signed [7:0]  sa;
    logic signed [7:0]  sb;
    logic signed [15:0] sp;
    for (int i = 0; i < 8; i++) begin
      sa = 8'($urandom);
      sb = 8'($urandom);
      sp = sa * sb;
      runOp(sa, sb, 1'b1, sp, "random_signed");
    end
  endtask

`ifdef BOOTH_UNSIGNED_EN
  task automatic test_unsigned();
    logic [7:0]  ua;
    logic [7:0]  ub;
    logic [15:0] up;
    runOp(8'hFF, 8'hFF, 1'b0, 16'hFE01, "unsigned_ff");
    for (int i = 0; i < 4; i++) begin
      ua = 8'($urandom);
      ub = 8'($urandom);
      up = {8'h00, ua} * {8'h00, ub};
      runOp(ua, ub, 1'b0, up, "random_unsigned");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_signed();
    test_start_held();
    test_async_reset();
    test_random();
`ifdef BOOTH_UNSIGNED_EN
    test_unsigned();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
